exe_stage: RTL and testbench

- Execute stage, directly downstream of the decode stage in the 3-stage pipeline.
- Consumes the ALU function select, the PC, the register addresses and the register-file read data.
- Computes ADD/OR/AND/XOR in a single cycle, and MULT with an iterative shift-add engine over multiple cycles.
- Drives the register-file write port, and drives `stall` back to fetch/decode while a multiply is in progress.

---
 rtl/exe_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_exe_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
//
// Execute stage of the 3-stage pipeline, directly downstream of decode.
// ADD/OR/AND/XOR complete in one cycle. MULT runs an iterative shift-add
// engine for DATA_WIDTH cycles while holding fetch/decode through `stall`.
// The register-file write port and the retiring PC are registered outputs.
//
// Optional build macro:
//   EXE_FWD_EN - forward the registered write-back value into operand A/B
//                when the immediately preceding instruction wrote the same
//                register (read-after-write bypass). Without it the operands
//                are always regA_data/regB_data and software must insert a
//                NOOP between dependent instructions.
//
// Parameters:
//   DATA_WIDTH - datapath width; must equal the `DATA_WIDTH macro in package.v
//   CNT_W      - multiply iteration counter width; 2**CNT_W > DATA_WIDTH
//
// Ports:
//   clock        in   pipeline clock
//   reset        in   synchronous, active-high
//   alu_fns_sel  in   0000 NOOP, 0001 ADD, 0011 OR, 0100 AND, 0101 XOR,
//                     0110 MULT; every other code behaves as NOOP
//   pc_exe       in   PC of the instruction being executed
//   regA_addr    in   rs1 address
//   regB_addr    in   rs2 address
//   regD_addr    in   rd address
//   regA_data    in   rs1 value, valid with alu_fns_sel
//   regB_data    in   rs2 value, valid with alu_fns_sel
//   wr_en        out  register-file write enable, one-cycle pulse (registered)
//   wr_addr      out  register-file write address (registered)
//   wr_data      out  register-file write data (registered)
//   pc_wb        out  PC of the retiring instruction (registered)
//   stall        out  combinational hold for fetch/decode
//
// Handshake: there is no valid/ready pair. Decode presents one instruction per
// cycle; whenever stall is high at the clock edge decode must keep presenting
// the same instruction. stall is low in the DONE cycle, so decode advances on
// that edge while the still-presented MULT is ignored by this stage.
//
// FSM state is held in `state` (IDLE/MUL/DONE) for debug visibility.
// -----------------------------------------------------------------------------
module exe_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            alu_fns_sel,
  input  logic [DATA_WIDTH-1:0] pc_exe,
  input  logic [4:0]            regA_addr,
  input  logic [4:0]            regB_addr,
  input  logic [4:0]            regD_addr,
  input  logic [DATA_WIDTH-1:0] regA_data,
  input  logic [DATA_WIDTH-1:0] regB_data,
  output logic                  wr_en,
  output logic [4:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] pc_wb,
  output logic                  stall
);

  // Function select encodings
  localparam logic [3:0] FN_NOOP = 4'b0000;
  localparam logic [3:0] FN_ADD  = 4'b0001;
  localparam logic [3:0] FN_OR   = 4'b0011;
  localparam logic [3:0] FN_AND  = 4'b0100;
  localparam logic [3:0] FN_XOR  = 4'b0101;
  localparam logic [3:0] FN_MULT = 4'b0110;

  // FSM states
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]            state;

  // Decoded operation
  logic                  is_single;
  logic                  is_mult;

  // Effective operands (possibly forwarded)
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_result;

  // Multiply engine
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [4:0]            mul_rd;
  logic [DATA_WIDTH-1:0] mul_pc;
  logic [CNT_W-1:0]      counter;

  // ---------------------------------------------------------------------------
  // Decode of the function select
  // ---------------------------------------------------------------------------
  always_comb begin
    is_single = 1'b0;
    is_mult   = 1'b0;
    case (alu_fns_sel)
      FN_ADD, FN_OR, FN_AND, FN_XOR: is_single = 1'b1;
      FN_MULT:                       is_mult   = 1'b1;
      default:                       ;  // FN_NOOP and undefined codes
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
`ifdef EXE_FWD_EN
  // The registered write port still carries the previous instruction's result
  // in the cycle the dependent instruction is here, so bypass it. The x0 check
  // is redundant with wr_en never firing for rd=0 but keeps the intent local.
  always_comb begin
    op_a = regA_data;
    op_b = regB_data;
    if (wr_en && (wr_addr == regA_addr) && (regA_addr != 5'd0)) begin
      op_a = wr_data;
    end
    if (wr_en && (wr_addr == regB_addr) && (regB_addr != 5'd0)) begin
      op_b = wr_data;
    end
  end
`else
  assign op_a = regA_data;
  assign op_b = regB_data;

  // Source addresses only matter for the bypass.
  logic addr_unused;
  assign addr_unused = ^{regA_addr, regB_addr};
`endif

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_result = '0;
    case (alu_fns_sel)
      FN_ADD:  alu_result = op_a + op_b;  // wraps modulo 2**DATA_WIDTH
      FN_OR:   alu_result = op_a | op_b;
      FN_AND:  alu_result = op_a & op_b;
      FN_XOR:  alu_result = op_a ^ op_b;
      default: alu_result = '0;
    endcase
  end

  // One shift-add step; the low DATA_WIDTH bits of the product are the same
  // for signed and unsigned operands, so no sign handling is needed.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // stall is a function of state and the decoded select only (never wr_en),
  // which keeps it free of any combinational path through the write port.
  assign stall = (state == MUL) || ((state == IDLE) && is_mult);

  // ---------------------------------------------------------------------------
  // FSM, multiply engine and registered write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      pc_wb   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_rd  <= '0;
      mul_pc  <= '0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_single) begin
            wr_en   <= (regD_addr != 5'd0);
            wr_addr <= regD_addr;
            wr_data <= alu_result;
            pc_wb   <= pc_exe;
          end else if (is_mult) begin
            mcand   <= op_a;
            mplier  <= op_b;
            acc     <= '0;
            mul_rd  <= regD_addr;
            mul_pc  <= pc_exe;
            counter <= CNT_W'(DATA_WIDTH);
            wr_en   <= 1'b0;
            state   <= MUL;
          end else begin
            // NOOP: retire the PC, leave address/data as they were
            wr_en <= 1'b0;
            pc_wb <= pc_exe;
          end
        end

        MUL: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            // Last step: acc_next already holds the full product
            wr_en   <= (mul_rd != 5'd0);
            wr_addr <= mul_rd;
            wr_data <= acc_next;
            pc_wb   <= mul_pc;
            state   <= DONE;
          end
        end

        DONE: begin
          // The MULT still presented by decode this cycle is the one that
          // just finished; it is dropped here.
          wr_en <= 1'b0;
          state <= IDLE;
        end

        default: begin
          wr_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
//
// Self-checking bench for exe_stage. Directed cases cover ALU ops, add wrap,
// MULT latency/results, rd=0, reset mid-multiply and operand bypass; a
// randomized instruction stream follows. Expected results come from a
// behavioural model using plain arithmetic on the architectural values.
// Writes are checked by a scoreboard fed from the expected queue.
// Inputs are driven on the falling edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_exe_stage;

  localparam int DW = 32;
  localparam int MUL_STALL = DW + 1;

  localparam logic [3:0] F_NOOP = 4'b0000;
  localparam logic [3:0] F_ADD  = 4'b0001;
  localparam logic [3:0] F_OR   = 4'b0011;
  localparam logic [3:0] F_AND  = 4'b0100;
  localparam logic [3:0] F_XOR  = 4'b0101;
  localparam logic [3:0] F_MULT = 4'b0110;

  logic          clock;
  logic          reset;
  logic [3:0]    alu_fns_sel;
  logic [DW-1:0] pc_exe;
  logic [4:0]    regA_addr;
  logic [4:0]    regB_addr;
  logic [4:0]    regD_addr;
  logic [DW-1:0] regA_data;
  logic [DW-1:0] regB_data;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] pc_wb;
  logic          stall;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected {wr_addr, wr_data} per write pulse
  logic [36:0] exp_q[$];

  // Model state
  logic          fwd_valid;
  logic [4:0]    fwd_addr;
  logic [DW-1:0] fwd_data;
  logic [4:0]    hold_addr;
  logic [DW-1:0] hold_data;

  exe_stage #(.DATA_WIDTH(DW), .CNT_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_fns_sel (alu_fns_sel),
    .pc_exe      (pc_exe),
    .regA_addr   (regA_addr),
    .regB_addr   (regB_addr),
    .regD_addr   (regD_addr),
    .regA_data   (regA_data),
    .regB_data   (regB_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pc_wb       (pc_wb),
    .stall       (stall)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] ref_op(input logic [3:0] fn,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (fn)
      F_ADD:   return a + b;
      F_OR:    return a | b;
      F_AND:   return a & b;
      F_XOR:   return a ^ b;
      F_MULT:  return prod[DW-1:0];
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] eff_operand(input logic [4:0] addr,
                                                input logic [DW-1:0] data);
    logic [DW-1:0] v;
    v = data;
`ifdef EXE_FWD_EN
    if (fwd_valid && (addr == fwd_addr) && (addr != 5'd0)) v = fwd_data;
`else
    if (addr == 5'd31 && 1'b0) v = '0;
`endif
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    if (!reset && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {27'd0, wr_addr, wr_data}, 64'd0);
      end else begin
        check("sb_write", {27'd0, wr_addr, wr_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [3:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                       input logic [DW-1:0] pc);
    alu_fns_sel = fn;
    regA_data   = a;
    regB_data   = b;
    regA_addr   = ra;
    regB_addr   = rb;
    regD_addr   = rd;
    pc_exe      = pc;
  endtask

  task automatic issue(input logic [3:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                       input logic [DW-1:0] pc);
    logic [DW-1:0] ea, eb, res;
    int cnt;
    ea  = eff_operand(ra, a);
    eb  = eff_operand(rb, b);
    res = ref_op(fn, ea, eb);
    drive(fn, a, b, ra, rb, rd, pc);
    #1;
    if (fn == F_ADD || fn == F_OR || fn == F_AND || fn == F_XOR) begin
      check("alu_stall", 64'(stall), 64'd0);
      if (rd != 5'd0) exp_q.push_back({rd, res});
      @(negedge clock);
      check("alu_wr_en", 64'(wr_en), 64'(rd != 5'd0));
      check("alu_wr_addr", 64'(wr_addr), 64'(rd));
      check("alu_wr_data", 64'(wr_data), 64'(res));
      check("alu_pc_wb", 64'(pc_wb), 64'(pc));
      hold_addr = rd;
      hold_data = res;
      fwd_valid = (rd != 5'd0);
      fwd_addr  = rd;
      fwd_data  = res;
    end else if (fn == F_MULT) begin
      check("mul_stall_issue", 64'(stall), 64'd1);
      if (rd != 5'd0) exp_q.push_back({rd, res});
      cnt = 1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        if (stall) cnt++;
        else break;
      end
      check("mul_stall_cycles", 64'(cnt), 64'(MUL_STALL));
      check("mul_wr_en", 64'(wr_en), 64'(rd != 5'd0));
      check("mul_wr_addr", 64'(wr_addr), 64'(rd));
      check("mul_wr_data", 64'(wr_data), 64'(res));
      check("mul_pc_wb", 64'(pc_wb), 64'(pc));
      // Decode still shows the MULT during DONE; it must not restart.
      @(negedge clock);
      check("mul_pulse_end", 64'(wr_en), 64'd0);
      check("mul_no_restart", 64'(dut.state), 64'd0);
      hold_addr = rd;
      hold_data = res;
      fwd_valid = 1'b0;
    end else begin
      check("noop_stall", 64'(stall), 64'd0);
      @(negedge clock);
      check("noop_wr_en", 64'(wr_en), 64'd0);
      check("noop_pc_wb", 64'(pc_wb), 64'(pc));
      check("noop_wr_addr_hold", 64'(wr_addr), 64'(hold_addr));
      check("noop_wr_data_hold", 64'(wr_data), 64'(hold_data));
      fwd_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(F_NOOP, '0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clock);
    reset     = 1'b0;
    fwd_valid = 1'b0;
    hold_addr = '0;
    hold_data = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"},   64'(wr_en),   64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_pc_wb"},   64'(pc_wb),   64'd0);
    check({tag, "_stall"},   64'(stall),   64'd0);
    check({tag, "_state"},   64'(dut.state), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [3:0] fn_tab [8];
  logic [DW-1:0] fwd_exp;

  initial begin
    fn_tab = '{F_NOOP, F_ADD, F_OR, F_AND, F_XOR, F_MULT, 4'b0010, 4'b1111};
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    hold_addr = '0;
    hold_data = '0;

    @(negedge clock);
    apply_reset();
    check_reset_values("reset");

    // Single-cycle ops
    issue(F_ADD, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'h0000_0100);
    issue(F_ADD, 32'hFFFF_FFFF, 32'd1, 5'd4, 5'd5, 5'd6, 32'h0000_0104);
    issue(F_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd4, 5'd5, 5'd7, 32'h0000_0108);
    check("xor_const", 64'(wr_data), 64'h0F0F_F0F0);
    issue(F_OR,  32'h1200_0034, 32'h0056_7800, 5'd8, 5'd9, 5'd10, 32'h0000_010C);
    issue(F_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd8, 5'd9, 5'd11, 32'h0000_0110);
    issue(F_NOOP, 32'd1, 32'd2, 5'd0, 5'd0, 5'd12, 32'h0000_0114);

    // Multiplies
    issue(F_MULT, 32'h0000_1234, 32'd3, 5'd1, 5'd2, 5'd5, 32'h0000_0200);
    check("mul_const", 64'(hold_data), 64'h369C);
    issue(F_ADD, 32'd10, 32'd20, 5'd1, 5'd2, 5'd13, 32'h0000_0204);
    issue(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd14, 32'h0000_0208);
    issue(F_MULT, 32'h0001_0000, 32'h0001_0000, 5'd1, 5'd2, 5'd15, 32'h0000_020C);

    // rd = 0 never writes
    issue(F_ADD, 32'd9, 32'd9, 5'd1, 5'd2, 5'd0, 32'h0000_0300);
    issue(F_MULT, 32'd6, 32'd7, 5'd1, 5'd2, 5'd0, 32'h0000_0304);

    // Reset in the 10th MUL cycle
    drive(F_MULT, 32'hDEAD_BEEF, 32'h1234_5678, 5'd1, 5'd2, 5'd9, 32'h0000_0400);
    repeat (10) @(negedge clock);
    check("rst_mid_stall_before", 64'(stall), 64'd1);
    reset = 1'b1;
    drive(F_NOOP, '0, '0, '0, '0, '0, '0);
    @(negedge clock);
    check_reset_values("rst_mid");
    reset     = 1'b0;
    fwd_valid = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    repeat (2) @(negedge clock);
    check("rst_mid_no_write", 64'(wr_en), 64'd0);

    // Back-to-back dependency
    issue(F_NOOP, '0, '0, 5'd0, 5'd0, 5'd0, 32'h0000_0500);
    issue(F_ADD, 32'd0, 32'd4, 5'd0, 5'd0, 5'd1, 32'h0000_0504);
    issue(F_ADD, 32'd0, 32'd0, 5'd1, 5'd1, 5'd2, 32'h0000_0508);
`ifdef EXE_FWD_EN
    fwd_exp = 32'd8;
`else
    fwd_exp = 32'd0;
`endif
    check("fwd_result", 64'(wr_data), 64'(fwd_exp));

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      logic [3:0]    fn;
      logic [DW-1:0] a, b;
      fn = fn_tab[$urandom_range(0, 7)];
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      issue(fn, a, b, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC);
    end

    issue(F_NOOP, '0, '0, 5'd0, 5'd0, 5'd0, 32'h0000_0600);
    repeat (2) @(negedge clock);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
